// File: rtl/mem_pkg.sv
// Shared definitions for the mem RAM bus masters.
//   mem_mode_t       : copy / fill operation select
//   mem_copy_state_t : mem_copy FSM states
package mem_pkg;

    typedef enum logic {
        MODE_COPY,
        MODE_FILL
    } mem_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mem_copy_state_t;

endpackage : mem_pkg

// File: rtl/mem_copy.sv
// mem_copy: copy / fill engine driving the ports of a mem dual-port RAM.
// Copy moves len words src->dst at one word per clock, fill writes a
// constant to len words at dst. Addresses wrap modulo SIZE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, accepted whenever busy = 0
//   mode                0 = copy, 1 = fill (sampled with start)
//   src, dst, len       source base, destination base, word count 0..SIZE
//   fill_data           fill value (sampled with start)
//   busy, done          operation in progress / one-cycle completion pulse
//   rd_addr, rd_data    RAM read port (one-cycle registered read)
//   wr_en, wr_addr,
//   wr_data             RAM write port
module mem_copy
    import mem_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int SIZE = 256,
    localparam int ADDR = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [ADDR-1:0] src,
    input  logic [ADDR-1:0] dst,
    input  logic [ADDR:0]   len,
    input  logic [XLEN-1:0] fill_data,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            wr_en,
    output logic [ADDR-1:0] wr_addr,
    output logic [XLEN-1:0] wr_data
);

    localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR + 1)'(1);

    mem_copy_state_t state;
    mem_mode_t       mode_q;
    logic [XLEN-1:0] fill_q;
    logic [ADDR:0]   cnt;     // reads (copy) or writes (fill) still to issue, incl. current

    assign wr_data = (mode_q == MODE_FILL) ? fill_q : rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    if (start) begin
                        mode_q  <= mem_mode_t'(mode);
                        fill_q  <= fill_data;
                        wr_addr <= dst;
                        cnt     <= len;
                        // Fill leaves the read port where it was.
                        if (mem_mode_t'(mode) == MODE_COPY) begin
                            rd_addr <= src;
                        end
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            // Copy's first write waits for the first read to return.
                            wr_en <= (mem_mode_t'(mode) == MODE_FILL);
                        end
                    end
                end

                RUN: begin
                    // wr_addr advances only after a write has been presented.
                    if (wr_en) begin
                        wr_addr <= wr_addr + ADDR_ONE;
                    end
                    if (mode_q == MODE_COPY) begin
                        wr_en <= 1'b1;
                        if (cnt == CNT_ONE) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_ONE;
                            cnt     <= cnt - CNT_ONE;
                        end
                    end else begin
                        if (cnt == CNT_ONE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            wr_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end

                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    wr_en <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_copy
